alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu.sv | 30 +++
 rtl/alu_seq.sv | 91 +++++++++
 tb/tb_alu_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, opcodes, sequencer states and opcode classification.
// Pure declarations; no timing or flow-control behaviour.
package alu_pkg;
  localparam int W = 32;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_ROL = 4'b1100;
  localparam logic [3:0] OP_ROR = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return op inside {OP_SRA, OP_SLL, OP_SRL, OP_ROL, OP_ROR};
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return is_shift(op) || (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT});
  endfunction
endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; shift-class ops move by exactly one bit position.
// Zero latency, no flow control; illegal opcodes yield 0.
module alu
  import alu_pkg::*;
(
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [3:0]   Op,
  output logic [W-1:0] Y,
  output logic         Zero
);
  always_comb begin
    Y = '0;
    case (Op)
      OP_ADD:  Y = A + B;
      OP_SUB:  Y = A - B;
      OP_AND:  Y = A & B;
      OP_OR:   Y = A | B;
      OP_NOT:  Y = ~A;
      OP_SRA:  Y = $signed(A) >>> 1;
      OP_SLL:  Y = A << 1;
      OP_SRL:  Y = A >> 1;
      OP_ROL:  Y = {A[W-2:0], A[W-1]};
      OP_ROR:  Y = {A[0], A[W-1:1]};
      default: Y = '0;
    endcase
  end

  assign Zero = (Y == '0);
endmodule

// File: rtl/alu_seq.sv
// Sequenced ALU: one ALU pass for logic/arith ops, ShAmt single-bit passes for shifts (DONE 1 or n edges after accept).
// Request accepted only in IDLE; the response is held in DONE until RspReady.
module alu_seq
  import alu_pkg::*;
(
  input  logic         Clk,
  input  logic         Resetn,
  input  logic         ReqValid,
  output logic         ReqReady,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [3:0]   Op,
  input  logic [4:0]   ShAmt,
  output logic         RspValid,
  input  logic         RspReady,
  output logic [W-1:0] Result,
  output logic         Zero,
  output logic         Err,
  output logic         Busy
);
  state_t       state;
  logic [W-1:0] OpA, OpB;
  logic [3:0]   OpC;
  logic [4:0]   Cnt;
  logic [W-1:0] alu_y;
  logic         alu_zero_unused;

  alu u_alu (
    .A    (OpA),
    .B    (OpB),
    .Op   (OpC),
    .Y    (alu_y),
    .Zero (alu_zero_unused)
  );

  assign ReqReady = (state == S_IDLE) && Resetn;
  assign RspValid = (state == S_DONE);
  assign Busy     = (state != S_IDLE);

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state  <= S_IDLE;
      OpA    <= '0;
      OpB    <= '0;
      OpC    <= '0;
      Cnt    <= '0;
      Result <= '0;
      Zero   <= 1'b1;
      Err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ReqValid) begin
            OpA   <= A;
            OpB   <= B;
            OpC   <= Op;
            Cnt   <= is_shift(Op) ? ShAmt : 5'd1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!is_legal(OpC)) begin
            Result <= '0;
            Zero   <= 1'b1;
            Err    <= 1'b1;
            state  <= S_DONE;
          end else if (Cnt == 5'd0) begin
            // zero-count shift: pass the captured operand through untouched
            Result <= OpA;
            Zero   <= (OpA == '0);
            Err    <= 1'b0;
            state  <= S_DONE;
          end else begin
            Cnt <= Cnt - 5'd1;
            if (is_shift(OpC)) OpA <= alu_y;
            if (Cnt == 5'd1) begin
              Result <= alu_y;
              Zero   <= (alu_y == '0);
              Err    <= 1'b0;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (RspReady) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Randomised scoreboard bench for alu_seq: driver pushes model expectations, monitor pops on each new response.
module tb_alu_seq;
  logic        Clk = 1'b0;
  logic        Resetn = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic [31:0] A = '0, B = '0;
  logic [3:0]  Op = '0;
  logic [4:0]  ShAmt = '0;
  logic        RspValid;
  logic        RspReady = 1'b0;
  logic [31:0] Result;
  logic        Zero, Err, Busy;

  alu_seq dut (
    .Clk(Clk), .Resetn(Resetn), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .A(A), .B(B), .Op(Op), .ShAmt(ShAmt), .RspValid(RspValid), .RspReady(RspReady),
    .Result(Result), .Zero(Zero), .Err(Err), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        e;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   bp = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference behaviour expressed as whole-shift arithmetic, not bit-by-bit iteration.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input logic [4:0] sh);
    exp_t x;
    int   n = int'(sh);
    x.e = 1'b0;
    x.lat = 1;
    x.acc = 0;
    case (op)
      4'b0000: x.r = a + b;
      4'b0001: x.r = a - b;
      4'b0010: x.r = a & b;
      4'b0011: x.r = a | b;
      4'b0100: x.r = ~a;
      4'b1000: x.r = $signed(a) >>> n;
      4'b1010: x.r = a >> n;
      4'b1001: x.r = a << n;
      4'b1100: x.r = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
      4'b1101: x.r = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
      default: begin x.r = '0; x.e = 1'b1; end
    endcase
    if (op inside {4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101} && n != 0) x.lat = n;
    x.z = (x.r == 32'd0);
    return x;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic [4:0] sh, input bit push);
    exp_t x;
    int   t = 0;
    @(negedge Clk);
    ReqValid = 1'b1; A = a; B = b; Op = op; ShAmt = sh;
    while (!ReqReady && t < 300) begin
      @(negedge Clk);
      t++;
    end
    if (!ReqReady) begin
      errors++;
      $display("FAIL accept_timeout actual=ReqReady low required=accept within 300 cycles");
    end
    if (push) begin
      x = model(a, b, op, sh);
      x.acc = cyc + 1;
      exp_q.push_back(x);
    end
    @(posedge Clk);
    #1;
    ReqValid = 1'b0;
    A = $urandom; B = $urandom; Op = 4'($urandom); ShAmt = 5'($urandom);
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      RspReady = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare on each new response, then demand stability while it is stalled.
  initial begin
    exp_t        x;
    bit          prev_vld = 1'b0;
    logic [31:0] hr;
    logic        hz, he;
    forever begin
      @(posedge Clk);
      #1;
      if (RspValid) check("rdy_low_in_done", 32'(ReqReady), 32'd0);
      if (RspValid && !prev_vld) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp actual=Result 0x%08h required=no response", Result);
        end else begin
          x = exp_q.pop_front();
          check("result", Result, x.r);
          check("zero", 32'(Zero), 32'(x.z));
          check("err", 32'(Err), 32'(x.e));
          check("latency", 32'(cyc - x.acc), 32'(x.lat));
        end
        hr = Result; hz = Zero; he = Err;
      end else if (RspValid && prev_vld) begin
        check("stall_result", Result, hr);
        check("stall_zero_err", {30'd0, Zero, Err}, {30'd0, hz, he});
      end
      prev_vld = RspValid;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_result"}, Result, 32'd0);
    check({tag, "_flags"}, {27'd0, Zero, Err, RspValid, Busy, ReqReady}, {27'd0, 5'b10000});
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || Busy) && t < 3000) begin
      @(negedge Clk);
      t++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int waited;
    repeat (3) @(negedge Clk);
    #1;
    check_reset_vals("reset");
    @(negedge Clk);
    Resetn = 1'b1;

    issue(32'd5, 32'd7, 4'b0000, 5'd0, 1);
    issue(32'h1234, 32'h1234, 4'b0001, 5'd3, 1);
    issue(32'h8000_0000, 32'd0, 4'b1000, 5'd4, 1);
    issue(32'd1, 32'd0, 4'b1100, 5'd31, 1);
    issue(32'hDEAD_BEEF, 32'd0, 4'b1001, 5'd0, 1);
    issue(32'hCAFE_F00D, 32'h1, 4'b0111, 5'd9, 1);
    issue(32'hF0F0_0F0F, 32'h0, 4'b0100, 5'd0, 1);
    issue(32'h8000_0001, 32'h0, 4'b1101, 5'd1, 1);

    for (int i = 0; i < 120; i++) begin
      logic [4:0] sh;
      sh = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if ($urandom_range(0, 1) == 0) sh = 5'($urandom_range(0, 3));
      issue($urandom, $urandom, 4'($urandom), sh, 1);
    end
    drain();

    // Backpressure: stall the response 5 cycles while the next request is already waiting.
    bp = 1'b1;
    issue(32'd100, 32'd23, 4'b0001, 5'd0, 1);
    fork
      issue(32'd3, 32'd4, 4'b0000, 5'd0, 1);
      begin
        waited = 0;
        while (!RspValid && waited < 50) begin
          @(negedge Clk);
          waited++;
        end
        check("bp_reached_done", 32'(RspValid), 32'd1);
        repeat (5) begin
          @(negedge Clk);
          check("bp_valid_held", {30'd0, RspValid, ReqReady}, {30'd0, 2'b10});
        end
        bp = 1'b0;
      end
    join
    drain();

    // Reset in RUN cycle 2 of a 10-step srl; that operation must vanish.
    issue(32'hFFFF_0000, 32'd0, 4'b1010, 5'd10, 0);
    @(negedge Clk);
    @(negedge Clk);
    check("busy_before_reset", 32'(Busy), 32'd1);
    Resetn = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    @(negedge Clk);
    #1;
    check_reset_vals("held_reset");
    @(negedge Clk);
    Resetn = 1'b1;
    issue(32'h7FFF_FFFF, 32'd1, 4'b0000, 5'd0, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
